// File: rtl/alu_sequencer.sv
// alu_sequencer: command front-end that steps the 64-bit ALU through load-primary, load-secondary and compute.
// Optional performance counters are built when ALU_SEQ_PERF_EN is defined.
module alu_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [63:0] cmd_a_i,
    input  logic [63:0] cmd_b_i,
    output logic [3:0]  alu_opcode_o,
    output logic [63:0] alu_input_o,
    input  logic [63:0] alu_output_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [63:0] res_data_o,
    output logic        res_err_o,
`ifdef ALU_SEQ_PERF_EN
    output logic [31:0] perf_cmds_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic        busy_o
);
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD_P = 4'h1;
    localparam logic [3:0] OP_LOAD_S = 4'h2;
    localparam logic [3:0] OP_XOR    = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_PASS_P = 4'h5;

    typedef enum logic [2:0] {IDLE, LOAD_P, LOAD_S, EXEC, HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] b_q, b_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [63:0] input_q, input_d;
    logic        valid_q, valid_d;
    logic [63:0] data_q, data_d;
    logic        err_q, err_d;
    logic [3:0]  exec_op;
    logic        illegal;

    assign illegal = op_q == 2'd3;
    assign exec_op = op_q == 2'd0 ? OP_XOR :
                     op_q == 2'd1 ? OP_ADD :
                     op_q == 2'd2 ? OP_PASS_P : OP_NOP;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        input_d  = input_q;
        valid_d  = valid_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                opcode_d = OP_NOP;
                input_d  = '0;
                if (cmd_valid_i) begin
                    state_d  = LOAD_P;
                    op_d     = cmd_op_i;
                    b_d      = cmd_b_i;
                    opcode_d = OP_LOAD_P;
                    input_d  = cmd_a_i;
                end
            end
            LOAD_P: begin
                state_d  = LOAD_S;
                opcode_d = OP_LOAD_S;
                input_d  = b_q;
            end
            LOAD_S: begin
                state_d  = EXEC;
                opcode_d = exec_op;
                input_d  = '0;
            end
            EXEC: begin
                state_d  = HOLD;
                opcode_d = OP_NOP;
                valid_d  = 1'b1;
                data_d   = illegal ? '0 : alu_output_i;
                err_d    = illegal;
            end
            HOLD: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            b_q      <= '0;
            opcode_q <= OP_NOP;
            input_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            opcode_q <= opcode_d;
            input_q  <= input_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready_o  = state_q == IDLE;
    assign busy_o       = state_q != IDLE || valid_q;
    assign alu_opcode_o = opcode_q;
    assign alu_input_o  = input_q;
    assign res_valid_o  = valid_q;
    assign res_data_o   = data_q;
    assign res_err_o    = err_q;

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] cmds_q, cmds_d, stall_q, stall_d;

    always_comb begin
        cmds_d  = cmds_q + {31'd0, state_q == HOLD && res_ready_i};
        stall_d = stall_q + {31'd0, state_q == HOLD && !res_ready_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmds_q  <= '0;
            stall_q <= '0;
        end else begin
            cmds_q  <= cmds_d;
            stall_q <= stall_d;
        end
    end

    assign perf_cmds_o  = cmds_q;
    assign perf_stall_o = stall_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural ALU.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [63:0] cmd_a = '0;
    logic [63:0] cmd_b = '0;
    logic [3:0]  alu_opcode;
    logic [63:0] alu_input;
    logic [63:0] alu_output;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        res_err;
    logic        busy;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] perf_cmds, perf_stall;
`endif

    int n_checks = 0;
    int n_fail = 0;

    alu_sequencer dut (
        .clk_i(clk),
        .rst_i(rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op),
        .cmd_a_i(cmd_a),
        .cmd_b_i(cmd_b),
        .alu_opcode_o(alu_opcode),
        .alu_input_o(alu_input),
        .alu_output_i(alu_output),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .res_data_o(res_data),
        .res_err_o(res_err),
`ifdef ALU_SEQ_PERF_EN
        .perf_cmds_o(perf_cmds),
        .perf_stall_o(perf_stall),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: two registers written by load opcodes, combinational result.
    logic [63:0] prim = '0, sec = '0;
    always @(posedge clk) begin
        if (alu_opcode == 4'h1) prim <= alu_input;
        if (alu_opcode == 4'h2) sec <= alu_input;
    end
    assign alu_output = alu_opcode == 4'h3 ? prim ^ sec :
                        alu_opcode == 4'h4 ? prim + sec :
                        alu_opcode == 4'h5 ? prim : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_data, input logic exp_err,
                           input logic [3:0] exp_exec, input int hold);
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a = ~a;
        cmd_b = ~b;
        check("loadp_opcode", alu_opcode, 4'h1);
        check("loadp_input", alu_input, a);
        check("loadp_ready", cmd_ready, 1'b0);
        check("loadp_busy", busy, 1'b1);
        @(negedge clk);
        check("loads_opcode", alu_opcode, 4'h2);
        check("loads_input", alu_input, b);
        @(negedge clk);
        check("exec_opcode", alu_opcode, exp_exec);
        check("exec_input", alu_input, 64'd0);
        check("exec_valid", res_valid, 1'b0);
        @(negedge clk);
        check("hold_valid", res_valid, 1'b1);
        check("hold_data", res_data, exp_data);
        check("hold_err", res_err, exp_err);
        check("hold_opcode", alu_opcode, 4'h0);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = i[0];
            cmd_a = 64'(i) * 64'h1111;
            @(negedge clk);
            check("stall_valid", res_valid, 1'b1);
            check("stall_data", res_data, exp_data);
            check("stall_ready", cmd_ready, 1'b0);
            check("stall_opcode", alu_opcode, 4'h0);
        end
        cmd_valid = 1'b0;
`ifdef ALU_SEQ_PERF_EN
        if (hold > 0) check("perf_stall", perf_stall, 64'(hold));
`endif
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("done_valid", res_valid, 1'b0);
        check("done_err", res_err, 1'b0);
        check("done_data", res_data, exp_data);
        check("done_ready", cmd_ready, 1'b1);
        check("done_busy", busy, 1'b0);
    endtask

    initial begin
        int acc_cyc[3];
        logic [63:0] b2b_exp[3];
        int k, nres;
        b2b_exp[0] = 64'h6;
        b2b_exp[1] = 64'd30;
        b2b_exp[2] = 64'h7;

        do_reset();
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_opcode", alu_opcode, 4'h0);
        check("rst_input", alu_input, 64'd0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_data", res_data, 64'd0);
        check("rst_err", res_err, 1'b0);
        check("rst_busy", busy, 1'b0);

        run_cmd(2'd0, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'hF0F00F0FF0F00F0F, 1'b0, 4'h3, 0);
        run_cmd(2'd1, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h1, 1'b0, 4'h4, 0);

        do_reset();
        run_cmd(2'd2, 64'h123, 64'hABC, 64'h123, 1'b0, 4'h5, 10);
`ifdef ALU_SEQ_PERF_EN
        check("perf_cmds", perf_cmds, 64'd1);
`endif

        run_cmd(2'd3, 64'h55, 64'hAA, 64'h0, 1'b1, 4'h0, 0);
        check("illegal_prim", prim, 64'h55);
        check("illegal_sec", sec, 64'hAA);
        run_cmd(2'd1, 64'd40, 64'd2, 64'd42, 1'b0, 4'h4, 0);

        // Asynchronous reset landing between edges while the sequencer is in LOAD_S.
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        cmd_a = 64'd100;
        cmd_b = 64'd200;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_opcode", alu_opcode, 4'h2);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", cmd_ready, 1'b1);
        check("arst_opcode", alu_opcode, 4'h0);
        check("arst_input", alu_input, 64'd0);
        check("arst_valid", res_valid, 1'b0);
        check("arst_data", res_data, 64'd0);
        check("arst_busy", busy, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_stale", res_valid, 1'b0);
        end
        run_cmd(2'd1, 64'd7, 64'd8, 64'd15, 1'b0, 4'h4, 0);

        // Back-to-back with valid and ready held high.
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        cmd_a = 64'd5;
        cmd_b = 64'd3;
        k = 0;
        nres = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (alu_opcode == 4'h1 && k < 3) begin
                acc_cyc[k] = c;
                k++;
                cmd_op = k == 1 ? 2'd1 : 2'd2;
                cmd_a = k == 1 ? 64'd10 : 64'd7;
                cmd_b = k == 1 ? 64'd20 : 64'd99;
                if (k == 3) cmd_valid = 1'b0;
            end
            if (res_valid && nres < 3) begin
                check("b2b_data", res_data, b2b_exp[nres]);
                nres++;
            end
        end
        check("b2b_accepts", 64'(k), 64'd3);
        check("b2b_results", 64'(nres), 64'd3);
        check("b2b_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'd5);
        check("b2b_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command front-end for the 64-bit ALU. Accepts {operation, operand A, operand B} commands over a valid/ready handshake. Sequences the ALU opcode and input bus through load-primary, load-secondary and compute steps, then captures output_o and holds it under a result valid/ready handshake. Sits between the hash-search controller and the alu instance; it is the only driver of the ALU's opcode_i and input_i.

Parameters:
OP_NOP, 4'h0, ALU opcode issued when idle (no register writes)
OP_LOAD_P, 4'h1, ALU opcode: primary <= input_i
OP_LOAD_S, 4'h2, ALU opcode: secondary <= input_i
OP_XOR, 4'h3, ALU opcode: output = primary ^ secondary
OP_ADD, 4'h4, ALU opcode: output = primary + secondary (mod 2^64)
OP_PASS_P, 4'h5, ALU opcode: output = primary

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  sequencer can accept a command
cmd_op_i  input  2  0=XOR, 1=ADD, 2=PASS_P, 3=illegal
cmd_a_i  input  64  operand A (to primary)
cmd_b_i  input  64  operand B (to secondary)
alu_opcode_o  output  4  to alu opcode_i
alu_input_o  output  64  to alu input_i
alu_output_i  input  64  from alu output_o
res_valid_o  output  1  result held
res_ready_i  input  1  consumer takes result
res_data_o  output  64  captured ALU result
res_err_o  output  1  command had cmd_op_i=3
busy_o  output  1  state != IDLE or res_valid_o=1

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high, rst_i.
- Reset values: state=IDLE, cmd_ready_o=1, alu_opcode_o=OP_NOP, alu_input_o=0, res_valid_o=0, res_data_o=0, res_err_o=0, busy_o=0.
- Reset mid-sequence aborts the command and discards latched operands and result. It returns to the reset values immediately, not waiting for a clock.
- FSM states: IDLE, LOAD_P, LOAD_S, EXEC, HOLD.
- cmd_ready_o is 1 only in IDLE. A command is accepted on a rising edge with cmd_valid_i & cmd_ready_o.
- On accept: latch op, A and B into internal registers, then go to LOAD_P.
- alu_opcode_o and alu_input_o are registered outputs and are stable for the whole cycle in each state.
- Per-state outputs and transitions:
  - LOAD_P: opcode=OP_LOAD_P, input=A. Next state LOAD_S.
  - LOAD_S: opcode=OP_LOAD_S, input=B. Next state EXEC.
  - EXEC: opcode from op (OP_XOR / OP_ADD / OP_PASS_P), input=0. On the closing edge, res_data_o <= alu_output_i and res_valid_o <= 1. Next state HOLD.
  - HOLD and IDLE: opcode=OP_NOP, input=0.
- Illegal op (3):
  - Sequencing is still LOAD_P, LOAD_S, then EXEC with opcode OP_NOP.
  - res_data_o = 0 and res_err_o = 1.
  - ALU registers hold A and B afterwards.
- Latency: accept edge E0. LOAD_P is presented in cycle E0..E1 and EXEC in cycle E2..E3. res_valid_o rises after E3, i.e. 3 cycles after accept.
- HOLD:
  - res_valid_o, res_data_o and res_err_o are stable while res_ready_i=0. No timeout.
  - On an edge with res_ready_i=1: res_valid_o <= 0, res_err_o <= 0, state <= IDLE. res_data_o keeps its last value.
- No bypass from HOLD to accept: the next command is accepted no earlier than one cycle after the result handshake. Minimum throughput is one command per 5 cycles.
- Inputs are ignored outside their handshake windows:
  - cmd_valid_i and cmd_*_i are don't-care outside IDLE.
  - res_ready_i is don't-care unless res_valid_o=1.
  - Operands are sampled only at accept, so changes to cmd_*_i after accept have no effect.
- Arithmetic: ADD wraps mod 2^64 inside the ALU. The carry-out is dropped and not reported.

Optional Feature:
ALU_SEQ_PERF_EN:
- With the macro defined, adds two outputs, perf_cmds_o[31:0] and perf_stall_o[31:0]. Both reset to 0 and wrap at 2^32 with no saturation.
- perf_cmds_o increments on each result handshake.
- perf_stall_o increments each cycle with state=HOLD and res_ready_i=0.
- Without the macro, neither port nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then XOR command with A=64'hFFFF0000FFFF0000, B=64'h0F0F0F0F0F0F0F0F and res_ready_i=1 -> required response:
  - opcode sequence 1,2,3,0.
  - res_valid_o high 3 cycles after accept.
  - res_data_o=64'hF0F00F0FF0F00F0F, res_err_o=0.
- ADD with A=64'hFFFFFFFFFFFFFFFF, B=64'h2 -> res_data_o=64'h1 (wrap), carry not reported.
- PASS_P with A=64'h123, B=64'hABC, res_ready_i held 0 for 10 cycles -> required response:
  - res_data_o=64'h123 and res_valid_o stable throughout.
  - cmd_ready_o=0 throughout, and cmd_valid_i pulses are ignored.
  - With ALU_SEQ_PERF_EN: perf_stall_o=10, then perf_cmds_o=1 after the handshake.
- cmd_op_i=3 -> required response:
  - opcode sequence 1,2,0,0.
  - res_err_o=1 and res_data_o=0.
  - The next legal command completes with res_err_o=0.
- Assert rst_i asynchronously (between edges) while in LOAD_S -> required response:
  - Outputs take reset values immediately.
  - The following command runs from LOAD_P with the new operands, and no stale result appears.
- Back-to-back commands with cmd_valid_i held 1 and res_ready_i=1 -> one accept every 5 cycles, with results in order.
